bcd_display_mux: RTL and testbench

Four-digit multiplexed seven-segment driver that consumes the 4-bit BCD digits produced by the decade counter chain, with digit 0 as the least significant. It snapshots the digits on a load strobe, time-multiplexes them onto one shared segment bus with a programmable refresh rate, and optionally blanks leading zeros. It is the last stage before the board pins. All outputs are registered.

---
 rtl/bcd_display_if.sv | 22 ++
 rtl/bcd_display_mux.sv | 99 +++++++++
 tb/tb_bcd_display_mux.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_if.sv
// Segment-driver bundle between the counter chain and the display mux.
// Master drives the digit snapshot; slave drives the board pins.
interface bcd_display_if;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        slot_tick;

  modport master (
    output load, digits_in, dp_in, lz_blank,
    input  an, seg, dp, slot_tick
  );

  modport slave (
    input  load, digits_in, dp_in, lz_blank,
    output an, seg, dp, slot_tick
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed seven-segment driver with leading-zero blanking.
// Snapshots BCD digits on load and scans them out with registered pins.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  bcd_display_if.slave  bus
);

  localparam int PW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pre;
  logic [1:0]    slot;
  logic [1:0]    slot_d;
  logic [15:0]   dreg;
  logic [3:0]    dpreg;
  logic          wrap;

  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_hi;
  logic [3:0]    an_hi;
  logic          z3, z2, z1;

  assign wrap = (pre == PMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= '0;
      slot   <= '0;
      slot_d <= '0;
      dreg   <= '0;
      dpreg  <= '0;
    end else begin
      pre    <= wrap ? '0 : pre + 1'b1;
      slot_d <= slot;
      if (wrap)
        slot <= slot + 2'd1;
      if (bus.load) begin
        dreg  <= bus.digits_in;
        dpreg <= bus.dp_in;
      end
    end
  end

  // A digit blanks only if it and every digit above it are zero.
  always_comb begin
    digit = dreg[{slot, 2'b00} +: 4];
    z3    = (dreg[15:12] == 4'd0);
    z2    = z3 && (dreg[11:8] == 4'd0);
    z1    = z2 && (dreg[7:4] == 4'd0);
    blank = 1'b0;
    unique case (slot)
      2'd3:    blank = bus.lz_blank && z3;
      2'd2:    blank = bus.lz_blank && z2;
      2'd1:    blank = bus.lz_blank && z1;
      default: blank = 1'b0;
    endcase
    an_hi = 4'b0001 << slot;
  end

  always_comb begin
    seg_hi = 7'h40;
    unique case (digit)
      4'd0:    seg_hi = 7'h3F;
      4'd1:    seg_hi = 7'h06;
      4'd2:    seg_hi = 7'h5B;
      4'd3:    seg_hi = 7'h4F;
      4'd4:    seg_hi = 7'h66;
      4'd5:    seg_hi = 7'h6D;
      4'd6:    seg_hi = 7'h7D;
      4'd7:    seg_hi = 7'h07;
      4'd8:    seg_hi = 7'h7F;
      4'd9:    seg_hi = 7'h6F;
      default: seg_hi = 7'h40;
    endcase
    if (blank)
      seg_hi = 7'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.an        <= {4{ACTIVE_LOW}};
      bus.seg       <= {7{ACTIVE_LOW}};
      bus.dp        <= ACTIVE_LOW;
      bus.slot_tick <= 1'b0;
    end else begin
      bus.an        <= an_hi ^ {4{ACTIVE_LOW}};
      bus.seg       <= seg_hi ^ {7{ACTIVE_LOW}};
      bus.dp        <= dpreg[slot] ^ ACTIVE_LOW;
      bus.slot_tick <= (slot != slot_d);
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux (REFRESH_DIV=4, active-low pins).
// Vector table covers decode/blanking; hand sequences cover reset and wrap.
module tb_bcd_display_mux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_display_if bus ();

  bcd_display_mux #(
    .REFRESH_DIV(4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0]     d;
    logic [3:0]      dpi;
    logic            lz;
    logic [3:0][6:0] s;
    logic [3:0]      dpo;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vt [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpi,
                         input logic lz);
    bus.digits_in = d;
    bus.dp_in     = dpi;
    bus.lz_blank  = lz;
    bus.load      = 1'b1;
    step();
    bus.load      = 1'b0;
  endtask

  task automatic wait_tick(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.slot_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({nm, "_tick_timeout"}, 0, 1);
  endtask

  // Positioned on a tick cycle: check four slots and their dwell.
  task automatic check_frame(input vec_t v, input int idx);
    int dig;
    int cnt;
    for (int k = 0; k < 4; k++) begin
      dig = -1;
      for (int j = 0; j < 4; j++)
        if (bus.an === ~(4'b0001 << j)) dig = j;
      if (dig < 0) begin
        chk($sformatf("v%0d_an", idx), {28'd0, bus.an}, 32'hE);
      end else begin
        chk($sformatf("v%0d_dig%0d_seg_dp", idx, dig),
            {24'd0, bus.seg, bus.dp},
            {24'd0, v.s[dig], v.dpo[dig]});
      end
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (bus.slot_tick !== 1'b1 && cnt < 20);
      chk($sformatf("v%0d_hold%0d", idx, k), cnt, 4);
    end
  endtask

  bit ok;
  int cnt;

  initial begin
    vt[0] = '{16'h1234, 4'b0010, 1'b0,
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1101};
    vt[1] = '{16'h0050, 4'b0000, 1'b1,
              {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vt[2] = '{16'h0000, 4'b0000, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vt[3] = '{16'h00A0, 4'b0000, 1'b0,
              {7'h40, 7'h40, 7'h3F, 7'h40}, 4'b1111};
    vt[4] = '{16'h0050, 4'b0000, 1'b0,
              {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
    vt[5] = '{16'h5678, 4'b1001, 1'b0,
              {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0110};
    vt[6] = '{16'h0F09, 4'b0000, 1'b1,
              {7'h7F, 7'h3F, 7'h40, 7'h10}, 4'b1111};
    vt[7] = '{16'h9000, 4'b0100, 1'b1,
              {7'h10, 7'h40, 7'h40, 7'h40}, 4'b1011};

    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    bus.lz_blank  = 1'b0;
    reset         = 1'b1;
    repeat (3) step();
    chk("rst_an",   {28'd0, bus.an},  32'hF);
    chk("rst_seg",  {25'd0, bus.seg}, 32'h7F);
    chk("rst_dp",   {31'd0, bus.dp},  32'h1);
    chk("rst_tick", {31'd0, bus.slot_tick}, 32'h0);

    reset = 1'b0;
    step();
    chk("rel_an",   {28'd0, bus.an},  32'hE);
    chk("rel_seg",  {25'd0, bus.seg}, 32'h40);
    chk("rel_tick", {31'd0, bus.slot_tick}, 32'h0);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (bus.slot_tick !== 1'b1 && cnt < 20);
    chk("first_tick_delay", cnt, 4);

    for (int i = 0; i < 8; i++) begin
      do_load(vt[i].d, vt[i].dpi, vt[i].lz);
      wait_tick($sformatf("v%0d", i), ok);
      if (ok) check_frame(vt[i], i);
    end

    // Load landing on the wrap cycle shows on the new slot's first cycle.
    do_load(16'h0000, 4'b0000, 1'b0);
    wait_tick("wrapld", ok);
    if (ok) begin
      step();
      step();
      chk("wrapld_old_seg", {25'd0, bus.seg}, 32'h40);
      bus.digits_in = 16'h9999;
      bus.load      = 1'b1;
      step();
      bus.load      = 1'b0;
      chk("wrapld_pre_seg", {25'd0, bus.seg}, 32'h40);
      chk("wrapld_pre_tick", {31'd0, bus.slot_tick}, 32'h0);
      step();
      chk("wrapld_tick", {31'd0, bus.slot_tick}, 32'h1);
      chk("wrapld_seg",  {25'd0, bus.seg}, 32'h10);
      step();
      chk("wrapld_tick_lo", {31'd0, bus.slot_tick}, 32'h0);
    end

    // Reset during slot 2 wipes the display registers.
    do_load(16'h4321, 4'b1111, 1'b0);
    cnt = 0;
    while (bus.an !== 4'b1011 && cnt < 20) begin
      step();
      cnt++;
    end
    chk("midrst_reach_slot2", {28'd0, bus.an}, 32'hB);
    reset = 1'b1;
    step();
    chk("midrst_an",   {28'd0, bus.an},  32'hF);
    chk("midrst_seg",  {25'd0, bus.seg}, 32'h7F);
    chk("midrst_dp",   {31'd0, bus.dp},  32'h1);
    chk("midrst_tick", {31'd0, bus.slot_tick}, 32'h0);
    reset = 1'b0;
    step();
    chk("midrst_rel_an",  {28'd0, bus.an},  32'hE);
    chk("midrst_rel_seg", {25'd0, bus.seg}, 32'h40);
    chk("midrst_rel_dp",  {31'd0, bus.dp},  32'h1);
    wait_tick("midrst", ok);
    if (ok) check_frame('{16'h0000, 4'b0000, 1'b0,
                          {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111}, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
